// File: rtl/branch_reg_arb_pkg.sv
// Shared types and constants for the branch destination register bus arbiter.
package branch_reg_arb_pkg;

    localparam int unsigned STATE_W = 2;
    localparam logic        CS_OFF  = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Cyclic priority picker: first asserted request at or after base wins.
module rr_priority_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] base,
    output logic [N-1:0]     onehot,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        logic [PTR_W-1:0] cand;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        cand   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = PTR_W'((32'(base) + k) % N);
            if (!valid && req[cand]) begin
                valid        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/branch_reg_bus_arbiter.sv
// Arbiter for a bank of branch destination registers on one tri-state Q bus.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (index 0 highest) instead of round-robin.
module branch_reg_bus_arbiter
    import branch_reg_arb_pkg::*;
#(
    parameter int unsigned NR_REQ  = 4,
    parameter int unsigned NR_REGS = 4,
    parameter int unsigned ADDR_W  = 2
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Tick,
    input  logic [NR_REQ-1:0]        req,
    input  logic [NR_REQ-1:0]        req_we,
    input  logic [NR_REQ*ADDR_W-1:0] req_addr,
    output logic [NR_REQ-1:0]        gnt,
    output logic [NR_REGS-1:0]       reg_ce,
    output logic [NR_REGS-1:0]       reg_cs,
    output logic                     addr_err,
    output logic                     busy
);

    localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NR_REQ-1:0]   gnt_q, gnt_d;
    logic [NR_REGS-1:0]  ce_q, ce_d;
    logic [NR_REGS-1:0]  cs_q, cs_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [IDX_W-1:0]    pick_base;
    logic [NR_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;

`ifdef ARB_FIXED_PRIORITY_EN
    assign pick_base = '0;
`else
    assign pick_base = rr_ptr_q;
`endif

    rr_priority_picker #(
        .N     (NR_REQ),
        .PTR_W (IDX_W)
    ) u_picker (
        .req    (req),
        .base   (pick_base),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Select the winner's access attributes
    always_comb begin
        win_we   = 1'b0;
        win_addr = '0;
        for (int unsigned i = 0; i < NR_REQ; i++) begin
            if (pick_onehot[i]) begin
                win_we   = req_we[i];
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next state, latched access, and registered-output decode from next state
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = '0;
        ce_d     = '0;
        cs_d     = {NR_REGS{CS_OFF}};
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    idx_d   = pick_idx;
                    we_d    = win_we;
                    addr_d  = win_addr;
`ifndef ARB_FIXED_PRIORITY_EN
                    if (32'(pick_idx) == NR_REQ - 1)
                        rr_ptr_d = '0;
                    else
                        rr_ptr_d = pick_idx + IDX_W'(1);
`endif
                end
            end
            ACCESS:  state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == ACCESS) begin
            for (int unsigned i = 0; i < NR_REQ; i++)
                gnt_d[i] = (idx_d == IDX_W'(i));
            if (32'(addr_d) >= NR_REGS) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned r = 0; r < NR_REGS; r++) begin
                    if (addr_d == ADDR_W'(r)) begin
                        if (we_d)
                            ce_d[r] = 1'b1;
                        else
                            cs_d[r] = ~CS_OFF;
                    end
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            ce_q     <= '0;
            cs_q     <= {NR_REGS{CS_OFF}};
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (Tick) begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            ce_q     <= ce_d;
            cs_q     <= cs_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign reg_ce   = ce_q;
    assign reg_cs   = cs_q;
    assign addr_err = err_q;
    assign busy     = busy_q;

endmodule
